// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the winner-take-all engine.
package maxnet_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ITER  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Width of the clamp-subtract operands; wide enough for any sum used here.
  localparam int unsigned CLAMP_W = 64;

  // Activation sum width: one carry bit per doubling of channel count.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned n_ch);
    return dw + $clog2(n_ch);
  endfunction

  // Full product width of EPS * (S - a_i) before the fractional shift.
  function automatic int unsigned prod_width(input int unsigned sw, input int unsigned frac);
    return sw + frac;
  endfunction

  // Unsigned a - b, floored at zero.
  function automatic logic [CLAMP_W-1:0] sub_clamp(input logic [CLAMP_W-1:0] a,
                                                   input logic [CLAMP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/maxnet_if.sv
// Control/data bundle between the engine and its host.
interface maxnet_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned IDXW = 2,
  parameter int unsigned ITW  = 7
);
  logic            start;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            busy;
  logic            done;
  logic [DW-1:0]   result;
  logic [IDXW-1:0] winner_idx;
  logic            no_winner;
  logic            timeout;
  logic [ITW-1:0]  iter_count;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, busy, done, result, winner_idx, no_winner, timeout, iter_count
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, busy, done, result, winner_idx, no_winner, timeout, iter_count
  );
endinterface

// File: rtl/maxnet_pu.sv
// One processing unit: holds a single activation and applies lateral inhibition.
module maxnet_pu
  import maxnet_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned SW   = 18,
  parameter int unsigned FRAC = 8,
  parameter int unsigned EPS  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [DW-1:0] load_val,
  input  logic          upd_en,
  input  logic [SW-1:0] sum,
  output logic [DW-1:0] act,
  output logic          zero_c
);

  localparam int unsigned PW = prod_width(SW, FRAC);

  logic [SW-1:0] diff;
  logic [PW-1:0] prod;
  logic [SW-1:0] inhib;
  logic [DW-1:0] nxt;

  // Inhibition from all other channels and the clamped next activation.
  always_comb begin
    diff  = sum - SW'(act);
    prod  = PW'(EPS) * PW'(diff);
    inhib = SW'(prod >> FRAC);
    nxt   = DW'(sub_clamp(CLAMP_W'(act), CLAMP_W'(inhib)));
  end

  // Activation register: load has priority over iteration update.
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= '0;
    end else if (load_en) begin
      act <= load_val;
    end else if (upd_en) begin
      act <= nxt;
    end
  end

  assign zero_c = (act == '0);

endmodule

// File: rtl/maxnet_engine.sv
// Winner-take-all engine: stream in N_CH activations, iterate inhibition,
// report the surviving channel (or the maximum on timeout).
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned EPS      = 64,
  parameter int unsigned MAX_ITER = 64
) (
  input logic     clk,
  input logic     rst,
  maxnet_if.slave bus
);

  localparam int unsigned IDXW = $clog2(N_CH);
  localparam int unsigned ITW  = $clog2(MAX_ITER + 1);
  localparam int unsigned SW   = sum_width(DW, N_CH);
  localparam int unsigned NZW  = $clog2(N_CH + 1);

  state_t          state;
  logic [IDXW-1:0] load_cnt;
  logic [ITW-1:0]  iter_cnt;
  logic            in_ready_q;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   result_q;
  logic [IDXW-1:0] winner_q;
  logic            no_winner_q;
  logic            timeout_q;

  logic [DW-1:0]   act [N_CH];
  logic [N_CH-1:0] zero;
  logic [N_CH-1:0] load_en;
  logic [DW-1:0]   load_val;
  logic            accept;
  logic            upd_en;
  logic [SW-1:0]   sum;
  logic [NZW-1:0]  nz;
  logic [IDXW-1:0] best_idx;
  logic [DW-1:0]   best_val;

  assign accept   = (state == LOAD) && bus.in_valid;
  assign upd_en   = (state == ITER);
  assign load_val = bus.in_data[DW-1] ? '0 : bus.in_data;

  // One-hot load strobe addressed by the load counter.
  always_comb begin
    load_en = '0;
    for (int i = 0; i < N_CH; i++) begin
      load_en[i] = accept && (load_cnt == IDXW'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pu
    maxnet_pu #(
      .DW   (DW),
      .SW   (SW),
      .FRAC (FRAC),
      .EPS  (EPS)
    ) u_pu (
      .clk      (clk),
      .rst      (rst),
      .load_en  (load_en[g]),
      .load_val (load_val),
      .upd_en   (upd_en),
      .sum      (sum),
      .act      (act[g]),
      .zero_c   (zero[g])
    );
  end

  // Activation sum, nonzero popcount and lowest-index argmax.
  always_comb begin
    sum      = '0;
    nz       = '0;
    best_idx = '0;
    best_val = act[0];
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + SW'(act[i]);
      if (!zero[i]) begin
        nz = nz + NZW'(1);
      end
      if (act[i] > best_val) begin
        best_val = act[i];
        best_idx = IDXW'(i);
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_cnt    <= '0;
      iter_cnt    <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      winner_q    <= '0;
      no_winner_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= LOAD;
            load_cnt    <= '0;
            iter_cnt    <= '0;
            done_q      <= 1'b0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            if (load_cnt == IDXW'(N_CH - 1)) begin
              state      <= CHECK;
              in_ready_q <= 1'b0;
            end else begin
              load_cnt <= load_cnt + IDXW'(1);
            end
          end
        end
        CHECK: begin
          if (nz <= NZW'(1)) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            no_winner_q <= (nz == '0);
            result_q    <= best_val;
            winner_q    <= best_idx;
          end else if (iter_cnt == ITW'(MAX_ITER)) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            result_q  <= best_val;
            winner_q  <= best_idx;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          iter_cnt <= iter_cnt + ITW'(1);
          state    <= CHECK;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.winner_idx = winner_q;
  assign bus.no_winner  = no_winner_q;
  assign bus.timeout    = timeout_q;
  assign bus.iter_count = iter_cnt;

endmodule
